// File: rtl/opti_pkg.sv
// Constants and types shared by the opti_sos datapath and its sample feeder.
package opti_pkg;

  localparam int DW_DEF        = 24;
  localparam int MULT_PIPE     = 12;
  localparam int ISSUE_GAP_DEF = MULT_PIPE + 3;

  localparam logic [2:0] COEF_B0 = 3'd0;
  localparam logic [2:0] COEF_B1 = 3'd1;
  localparam logic [2:0] COEF_B2 = 3'd2;
  localparam logic [2:0] COEF_A1 = 3'd3;
  localparam logic [2:0] COEF_A2 = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_GAP   = 2'd2,
    ST_COEF  = 2'd3
  } feeder_state_e;

  function automatic logic coef_addr_valid(input logic [2:0] addr);
    return (addr <= COEF_A2);
  endfunction

endpackage

// File: rtl/opti_sos_feeder_if.sv
// Bus bundle between the sample source / coefficient writer and the SOS feeder.
interface opti_sos_feeder_if
  import opti_pkg::*;
#(
  parameter int DW    = DW_DEF,
  parameter int DEPTH = 8
);
  logic                     s_valid;
  logic                     s_ready;
  logic [DW-1:0]            s_data;
  logic                     coef_wr_en;
  logic                     coef_wr_ready;
  logic [2:0]               coef_wr_addr;
  logic [DW-1:0]            coef_wr_data;
  logic                     sos_valid;
  logic [DW-1:0]            sos_data;
  logic [DW-1:0]            b0;
  logic [DW-1:0]            b1;
  logic [DW-1:0]            b2;
  logic [DW-1:0]            a1;
  logic [DW-1:0]            a2;
  logic                     sos_done;
  logic                     busy;
  logic [$clog2(DEPTH):0]   fifo_level;

  modport master (
    output s_valid, s_data, coef_wr_en, coef_wr_addr, coef_wr_data, sos_done,
    input  s_ready, coef_wr_ready, sos_valid, sos_data, b0, b1, b2, a1, a2, busy, fifo_level
  );

  modport slave (
    input  s_valid, s_data, coef_wr_en, coef_wr_addr, coef_wr_data, sos_done,
    output s_ready, coef_wr_ready, sos_valid, sos_data, b0, b1, b2, a1, a2, busy, fifo_level
  );
endinterface

// File: rtl/opti_sync_fifo.sv
// Single-clock FIFO; push is refused when full and pop when empty, pointers wrap modulo DEPTH.
module opti_sync_fifo #(
  parameter int DW    = 24,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_push,
  input  logic                   i_pop,
  input  logic [DW-1:0]          i_data,
  output logic [DW-1:0]          o_data,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_level
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [DW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [LW-1:0] r_level;
  logic          w_do_push;
  logic          w_do_pop;

  assign o_full    = (r_level == LW'(DEPTH));
  assign o_empty   = (r_level == '0);
  assign w_do_push = i_push & ~o_full;
  assign w_do_pop  = i_pop & ~o_empty;
  assign o_data    = r_mem[r_rd_ptr];
  assign o_level   = r_level;

  // storage, pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= r_wr_ptr + AW'(1);
      end
      if (w_do_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/opti_sos_feeder.sv
// Feeds queued samples to the SOS stage at a fixed minimum spacing and hands over coefficients.
// Build macro OPTI_FEEDER_COEF_SHADOW_EN enables shadowed coefficient updates via a COEF state.
module opti_sos_feeder
  import opti_pkg::*;
#(
  parameter int DW        = DW_DEF,
  parameter int DEPTH     = 8,
  parameter int ISSUE_GAP = ISSUE_GAP_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  opti_sos_feeder_if.slave bus
);
  localparam int LW       = $clog2(DEPTH) + 1;
  localparam int OW       = $clog2(DEPTH) + 2;
  localparam int GW       = $clog2(ISSUE_GAP);
  // ISSUE and the IDLE decision cycle each take one slot of the spacing
  localparam int GAP_LAST = (ISSUE_GAP > 2) ? ISSUE_GAP - 3 : 0;
  localparam feeder_state_e ST_AFTER_ISSUE = (ISSUE_GAP > 2) ? ST_GAP : ST_IDLE;

  feeder_state_e r_state;
  feeder_state_e w_state_nxt;
  logic [GW-1:0] r_gap_cnt;
  logic [OW-1:0] r_outstanding;
  logic          r_sos_valid;
  logic [DW-1:0] r_sos_data;
  logic [DW-1:0] r_b0, r_b1, r_b2, r_a1, r_a2;
  logic [DW-1:0] w_fifo_head;
  logic          w_full;
  logic          w_empty;
  logic [LW-1:0] w_level;
  logic          w_pop;
  logic          w_pending;
  logic          w_out_zero;
  logic          w_inc;
  logic          w_dec;
  logic          w_coef_ready;
  logic          w_wr_acc;

  opti_sync_fifo #(.DW(DW), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (bus.s_valid),
    .i_pop   (w_pop),
    .i_data  (bus.s_data),
    .o_data  (w_fifo_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (w_level)
  );

  assign w_pop      = (r_state == ST_ISSUE);
  assign w_out_zero = (r_outstanding == '0);
  assign w_inc      = (r_state == ST_ISSUE);
  assign w_dec      = bus.sos_done & ~w_out_zero;

  // next-state: a pending coefficient update blocks further issues
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_pending) begin
          if (w_out_zero) w_state_nxt = ST_COEF;
          else            w_state_nxt = ST_IDLE;
        end else if (!w_empty) begin
          w_state_nxt = ST_ISSUE;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_ISSUE: w_state_nxt = ST_AFTER_ISSUE;
      ST_GAP: begin
        if (r_gap_cnt == GW'(GAP_LAST)) w_state_nxt = ST_IDLE;
        else                            w_state_nxt = ST_GAP;
      end
      ST_COEF: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // state register and gap timer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_gap_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_gap_cnt <= (r_state == ST_GAP) ? r_gap_cnt + GW'(1) : '0;
    end
  end

  // issue register: data is captured from the head the cycle before it is popped
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sos_valid <= 1'b0;
      r_sos_data  <= '0;
    end else begin
      r_sos_valid <= (w_state_nxt == ST_ISSUE);
      if (w_state_nxt == ST_ISSUE) r_sos_data <= w_fifo_head;
    end
  end

  // samples in flight inside the SOS stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_outstanding <= '0;
    end else begin
      case ({w_inc, w_dec})
        2'b10:   r_outstanding <= r_outstanding + OW'(1);
        2'b01:   r_outstanding <= r_outstanding - OW'(1);
        default: r_outstanding <= r_outstanding;
      endcase
    end
  end

`ifndef SYNTHESIS
  logic r_done_underflow;

  // sticky record of a retire pulse with nothing in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          r_done_underflow <= 1'b0;
    else if (bus.sos_done && w_out_zero) r_done_underflow <= 1'b1;
  end
`endif

`ifdef OPTI_FEEDER_COEF_SHADOW_EN
  logic [DW-1:0] r_sh_b0, r_sh_b1, r_sh_b2, r_sh_a1, r_sh_a2;
  logic          r_pending;

  assign w_coef_ready = 1'b1;
  assign w_wr_acc     = bus.coef_wr_en & coef_addr_valid(bus.coef_wr_addr);
  assign w_pending    = r_pending;

  // shadow bank accepts writes at any time
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sh_b0 <= '0; r_sh_b1 <= '0; r_sh_b2 <= '0; r_sh_a1 <= '0; r_sh_a2 <= '0;
    end else if (bus.coef_wr_en) begin
      case (bus.coef_wr_addr)
        COEF_B0: r_sh_b0 <= bus.coef_wr_data;
        COEF_B1: r_sh_b1 <= bus.coef_wr_data;
        COEF_B2: r_sh_b2 <= bus.coef_wr_data;
        COEF_A1: r_sh_a1 <= bus.coef_wr_data;
        COEF_A2: r_sh_a2 <= bus.coef_wr_data;
        default: begin end
      endcase
    end
  end

  // a write landing in the COEF cycle re-arms the update
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    r_pending <= 1'b0;
    else if (w_wr_acc)             r_pending <= 1'b1;
    else if (r_state == ST_COEF)   r_pending <= 1'b0;
  end

  // live coefficients move only in COEF, which requires an empty SOS pipeline
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_b0 <= '0; r_b1 <= '0; r_b2 <= '0; r_a1 <= '0; r_a2 <= '0;
    end else if (r_state == ST_COEF) begin
      r_b0 <= r_sh_b0; r_b1 <= r_sh_b1; r_b2 <= r_sh_b2; r_a1 <= r_sh_a1; r_a2 <= r_sh_a2;
    end
  end
`else
  assign w_coef_ready = (r_state == ST_IDLE) & w_empty & w_out_zero;
  assign w_wr_acc     = bus.coef_wr_en & w_coef_ready;
  assign w_pending    = 1'b0;

  // direct writes, only accepted while the feeder and SOS stage are fully idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_b0 <= '0; r_b1 <= '0; r_b2 <= '0; r_a1 <= '0; r_a2 <= '0;
    end else if (w_wr_acc) begin
      case (bus.coef_wr_addr)
        COEF_B0: r_b0 <= bus.coef_wr_data;
        COEF_B1: r_b1 <= bus.coef_wr_data;
        COEF_B2: r_b2 <= bus.coef_wr_data;
        COEF_A1: r_a1 <= bus.coef_wr_data;
        COEF_A2: r_a2 <= bus.coef_wr_data;
        default: begin end
      endcase
    end
  end
`endif

  assign bus.s_ready       = ~w_full;
  assign bus.coef_wr_ready = w_coef_ready;
  assign bus.sos_valid     = r_sos_valid;
  assign bus.sos_data      = r_sos_data;
  assign bus.b0            = r_b0;
  assign bus.b1            = r_b1;
  assign bus.b2            = r_b2;
  assign bus.a1            = r_a1;
  assign bus.a2            = r_a2;
  assign bus.busy          = ~w_empty | ~w_out_zero | (r_state != ST_IDLE);
  assign bus.fifo_level    = w_level;

endmodule

// File: tb/tb_opti_sos_feeder.sv
// Directed bench for opti_sos_feeder; expected values are hand-derived constants.
module tb_opti_sos_feeder;
  import opti_pkg::*;

  localparam int DW    = 24;
  localparam int DEPTH = 8;
  localparam int GAP   = 15;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;
  int   iss_cyc[$];
  logic [DW-1:0] iss_dat[$];
  logic [DW-1:0] burst [8] = '{24'h111111, 24'h222222, 24'h333333, 24'h444444,
                               24'h555555, 24'h666666, 24'h777777, 24'h888888};
  logic [DW-1:0] exp_seq [9];

  always #5 clk = ~clk;

  opti_sos_feeder_if #(.DW(DW), .DEPTH(DEPTH)) bus ();

  opti_sos_feeder #(.DW(DW), .DEPTH(DEPTH), .ISSUE_GAP(GAP)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always @(posedge clk) cyc <= cyc + 1;

  // issue log sampled mid-cycle
  always @(negedge clk) begin
    if (bus.sos_valid === 1'b1) begin
      iss_cyc.push_back(cyc);
      iss_dat.push_back(bus.sos_data);
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget && bus.busy; i++) tick();
    check_val("idle_reached", 32'(bus.busy), 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    bus.s_valid = 1'b0;  bus.s_data = '0;
    bus.coef_wr_en = 1'b0; bus.coef_wr_addr = 3'd0; bus.coef_wr_data = '0;
    bus.sos_done = 1'b0;

    // reset state
    repeat (3) tick();
    check_val("rst_sos_valid", 32'(bus.sos_valid), 32'h0);
    check_val("rst_s_ready", 32'(bus.s_ready), 32'h1);
    check_val("rst_coef_ready", 32'(bus.coef_wr_ready), 32'h1);
    check_val("rst_level", 32'(bus.fifo_level), 32'h0);
    check_val("rst_busy", 32'(bus.busy), 32'h0);
    rst_n = 1'b1;
    tick();

    // single sample: visible two cycles after the push cycle
    bus.s_valid = 1'b1; bus.s_data = 24'h100000;
    tick();
    bus.s_valid = 1'b0;
    check_val("single_level", 32'(bus.fifo_level), 32'h1);
    check_val("single_early", 32'(bus.sos_valid), 32'h0);
    tick();
    check_val("single_valid", 32'(bus.sos_valid), 32'h1);
    check_val("single_data", 32'(bus.sos_data), 32'h100000);
    check_val("single_busy", 32'(bus.busy), 32'h1);
    tick();
    check_val("single_pulse", 32'(bus.sos_valid), 32'h0);
    check_val("single_hold", 32'(bus.sos_data), 32'h100000);
    check_val("single_out1", 32'(dut.r_outstanding), 32'h1);
`ifndef OPTI_FEEDER_COEF_SHADOW_EN
    check_val("busy_coef_ready", 32'(bus.coef_wr_ready), 32'h0);
    bus.coef_wr_en = 1'b1; bus.coef_wr_addr = COEF_A1; bus.coef_wr_data = 24'h0ABCDE;
    tick();
    bus.coef_wr_en = 1'b0;
    check_val("busy_write_dropped", 32'(bus.a1), 32'h0);
`endif
    repeat (4) tick();
    check_val("single_out_hold", 32'(dut.r_outstanding), 32'h1);
    bus.sos_done = 1'b1;
    tick();
    bus.sos_done = 1'b0;
    check_val("single_out0", 32'(dut.r_outstanding), 32'h0);
    wait_idle(40);

`ifndef OPTI_FEEDER_COEF_SHADOW_EN
    // direct coefficient write when idle
    check_val("idle_coef_ready", 32'(bus.coef_wr_ready), 32'h1);
    bus.coef_wr_en = 1'b1; bus.coef_wr_addr = COEF_A1; bus.coef_wr_data = 24'hC00000;
    tick();
    check_val("a1_write", 32'(bus.a1), 32'hC00000);
    check_val("b0_untouched", 32'(bus.b0), 32'h0);
    bus.coef_wr_addr = 3'd5; bus.coef_wr_data = 24'h123456;
    tick();
    bus.coef_wr_en = 1'b0;
    check_val("addr5_b0", 32'(bus.b0), 32'h0);
    check_val("addr5_a2", 32'(bus.a2), 32'h0);
    check_val("addr5_a1", 32'(bus.a1), 32'hC00000);
`else
    // shadowed swap: three in flight, then b0 write, then one queued sample
    bus.s_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin bus.s_data = 24'h000100 + 24'(i); tick(); end
    bus.s_valid = 1'b0;
    for (int i = 0; i < 60 && dut.r_outstanding != 3; i++) tick();
    check_val("sh_out3", 32'(dut.r_outstanding), 32'h3);
    bus.coef_wr_en = 1'b1; bus.coef_wr_addr = COEF_B0; bus.coef_wr_data = 24'h200000;
    tick();
    bus.coef_wr_en = 1'b0;
    bus.s_valid = 1'b1; bus.s_data = 24'h000777;
    tick();
    bus.s_valid = 1'b0;
    repeat (20) tick();
    check_val("sh_b0_held", 32'(bus.b0), 32'h0);
    check_val("sh_queued", 32'(bus.fifo_level), 32'h1);
    bus.sos_done = 1'b1;
    repeat (3) tick();
    bus.sos_done = 1'b0;
    check_val("sh_out0", 32'(dut.r_outstanding), 32'h0);
    check_val("sh_b0_pre", 32'(bus.b0), 32'h0);
    tick();
    check_val("sh_state_coef", 32'(dut.r_state), 32'(ST_COEF));
    check_val("sh_b0_coef", 32'(bus.b0), 32'h0);
    tick();
    check_val("sh_b0_new", 32'(bus.b0), 32'h200000);
    for (int i = 0; i < 5 && !bus.sos_valid; i++) tick();
    check_val("sh_resume_valid", 32'(bus.sos_valid), 32'h1);
    check_val("sh_resume_data", 32'(bus.sos_data), 32'h000777);
    bus.sos_done = 1'b1;
    tick();
    bus.sos_done = 1'b0;
    wait_idle(40);
`endif

    // burst: eight samples land behind an issued lead sample
    iss_cyc.delete(); iss_dat.delete();
    exp_seq[0] = 24'hA00000;
    for (int i = 0; i < 8; i++) exp_seq[i+1] = burst[i];
    bus.s_valid = 1'b1; bus.s_data = 24'hA00000;
    tick();
    bus.s_valid = 1'b0;
    for (int i = 0; i < 10 && !bus.sos_valid; i++) tick();
    check_val("lead_issue", 32'(bus.sos_valid), 32'h1);
    bus.s_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin bus.s_data = burst[i]; tick(); end
    check_val("full_s_ready", 32'(bus.s_ready), 32'h0);
    check_val("full_level", 32'(bus.fifo_level), 32'h8);
    bus.s_data = 24'hBADBAD;
    for (int i = 0; i < 20 && !bus.sos_valid; i++) tick();
    check_val("burst_issue", 32'(bus.sos_valid), 32'h1);
    bus.sos_done = 1'b1;
    tick();
    bus.sos_done = 1'b0;
    bus.s_valid = 1'b0;
    check_val("pop_no_push_level", 32'(bus.fifo_level), 32'h7);
    check_val("issue_done_out", 32'(dut.r_outstanding), 32'h1);
    for (int i = 0; i < 150 && iss_cyc.size() < 9; i++) tick();
    for (int i = 0; i < 20 && dut.r_state != ST_IDLE; i++) tick();
    check_val("issue_count", 32'(iss_cyc.size()), 32'd9);
    for (int i = 0; i < iss_dat.size() && i < 9; i++) check_val("issue_order", 32'(iss_dat[i]), 32'(exp_seq[i]));
    for (int i = 1; i < iss_cyc.size() && i < 9; i++) check_val("issue_spacing", 32'(iss_cyc[i] - iss_cyc[i-1]), 32'd15);
    check_val("burst_hold_data", 32'(bus.sos_data), 32'h888888);
    check_val("burst_out8", 32'(dut.r_outstanding), 32'h8);

    // retire everything, then one spurious retire
    bus.sos_done = 1'b1;
    repeat (8) tick();
    bus.sos_done = 1'b0;
    check_val("drain_out0", 32'(dut.r_outstanding), 32'h0);
    check_val("no_underflow", 32'(dut.r_done_underflow), 32'h0);
    bus.sos_done = 1'b1;
    tick();
    bus.sos_done = 1'b0;
    check_val("underflow_out", 32'(dut.r_outstanding), 32'h0);
    check_val("underflow_flag", 32'(dut.r_done_underflow), 32'h1);
    check_val("drain_busy", 32'(bus.busy), 32'h0);

    // reset in GAP with four queued
    bus.s_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin bus.s_data = 24'h000050 + 24'(i); tick(); end
    bus.s_valid = 1'b0;
    check_val("pre_rst_level", 32'(bus.fifo_level), 32'h4);
    check_val("pre_rst_state", 32'(dut.r_state), 32'(ST_GAP));
    rst_n = 1'b0;
    #2;
    check_val("mid_rst_level", 32'(bus.fifo_level), 32'h0);
    check_val("mid_rst_valid", 32'(bus.sos_valid), 32'h0);
    check_val("mid_rst_data", 32'(bus.sos_data), 32'h0);
    check_val("mid_rst_a1", 32'(bus.a1), 32'h0);
    check_val("mid_rst_b0", 32'(bus.b0), 32'h0);
    check_val("mid_rst_out", 32'(dut.r_outstanding), 32'h0);
    check_val("mid_rst_busy", 32'(bus.busy), 32'h0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    check_val("post_rst_s_ready", 32'(bus.s_ready), 32'h1);
    check_val("post_rst_level", 32'(bus.fifo_level), 32'h0);
    check_val("post_rst_state", 32'(dut.r_state), 32'(ST_IDLE));
    check_val("post_rst_coef_ready", 32'(bus.coef_wr_ready), 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
